// File: rtl/i2c_slave_ram_port.sv
// I2C slave that streams bytes from the slave RAM controller read port onto SDA.
// A write transaction loads the 5-bit RAM pointer; each data byte read advances it.
module i2c_slave_ram_port #(
  parameter logic [6:0]  SLAVE_ADDR = 7'h42,
  parameter int unsigned RAM_RD_LAT = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl_i,
  input  logic       sda_i,
  output logic       sda_oe,
  output logic [4:0] slaveRAM_RADD,
  input  logic [7:0] slaveRAM_DOUT,
  output logic       busy,
  output logic       xfer_done
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, TX, TX_ACK, IGNORE
  } state_e;

  localparam int PfW = $clog2(RAM_RD_LAT + 2);
  localparam logic [PfW-1:0] PfStart = PfW'(RAM_RD_LAT + 1);
  localparam logic [PfW-1:0] PfOne   = PfW'(1);

  logic sclMeta_q, sclSync_q, sclPrev_q;
  logic sdaMeta_q, sdaSync_q, sdaPrev_q;

  state_e         state_q, state_d;
  logic [3:0]     bitCnt_q, bitCnt_d;
  logic [7:0]     shift_q, shift_d;
  logic [4:0]     ptr_q, ptr_d;
  logic [4:0]     radd_q, radd_d;
  logic [PfW-1:0] pfCnt_q, pfCnt_d;
  logic           sdaOe_q, sdaOe_d;
  logic           busy_q, busy_d;
  logic           xferDone_q, xferDone_d;
  logic           matched_q, matched_d;
  logic           rw_q, rw_d;
  logic           ptrSet_q, ptrSet_d;

  logic       sclRise, sclFall, startDet, stopDet;
  logic [7:0] byteIn;

  // Synchronisers reset to the idle-bus level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclMeta_q <= 1'b1;
      sclSync_q <= 1'b1;
      sclPrev_q <= 1'b1;
      sdaMeta_q <= 1'b1;
      sdaSync_q <= 1'b1;
      sdaPrev_q <= 1'b1;
    end else begin
      sclMeta_q <= scl_i;
      sclSync_q <= sclMeta_q;
      sclPrev_q <= sclSync_q;
      sdaMeta_q <= sda_i;
      sdaSync_q <= sdaMeta_q;
      sdaPrev_q <= sdaSync_q;
    end
  end

  assign sclRise  = sclSync_q & ~sclPrev_q;
  assign sclFall  = ~sclSync_q & sclPrev_q;
  assign startDet = sclSync_q & ~sdaSync_q & sdaPrev_q;
  assign stopDet  = sclSync_q & sdaSync_q & ~sdaPrev_q;
  assign byteIn   = {shift_q[6:0], sdaSync_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      bitCnt_q   <= '0;
      shift_q    <= '0;
      ptr_q      <= '0;
      radd_q     <= '0;
      pfCnt_q    <= '0;
      sdaOe_q    <= 1'b0;
      busy_q     <= 1'b0;
      xferDone_q <= 1'b0;
      matched_q  <= 1'b0;
      rw_q       <= 1'b0;
      ptrSet_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      bitCnt_q   <= bitCnt_d;
      shift_q    <= shift_d;
      ptr_q      <= ptr_d;
      radd_q     <= radd_d;
      pfCnt_q    <= pfCnt_d;
      sdaOe_q    <= sdaOe_d;
      busy_q     <= busy_d;
      xferDone_q <= xferDone_d;
      matched_q  <= matched_d;
      rw_q       <= rw_d;
      ptrSet_q   <= ptrSet_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    bitCnt_d   = bitCnt_q;
    shift_d    = shift_q;
    ptr_d      = ptr_q;
    radd_d     = radd_q;
    pfCnt_d    = pfCnt_q;
    sdaOe_d    = sdaOe_q;
    busy_d     = busy_q;
    xferDone_d = 1'b0;
    matched_d  = matched_q;
    rw_d       = rw_q;
    ptrSet_d   = ptrSet_q;

    // Prefetch countdown: the shift register captures DOUT once the RAM latency has elapsed.
    if (pfCnt_q != '0) begin
      pfCnt_d = pfCnt_q - PfOne;
      if (pfCnt_q == PfOne) begin
        shift_d = slaveRAM_DOUT;
      end
    end

    if (stopDet) begin
      state_d    = IDLE;
      sdaOe_d    = 1'b0;
      busy_d     = 1'b0;
      xferDone_d = matched_q;
      matched_d  = 1'b0;
    end else if (startDet) begin
      state_d   = ADDR;
      bitCnt_d  = '0;
      busy_d    = 1'b1;
      matched_d = 1'b0;
      ptrSet_d  = 1'b0;
    end else begin
      case (state_q)
        ADDR: begin
          if (sclRise) begin
            shift_d  = byteIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              if (byteIn[7:1] == SLAVE_ADDR) begin
                matched_d = 1'b1;
                rw_d      = byteIn[0];
                state_d   = ADDR_ACK;
                if (byteIn[0]) begin
                  radd_d  = ptr_q;
                  pfCnt_d = PfStart;
                end
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        // bitCnt 8 = waiting for the fall that opens the ACK slot, 9 = inside it.
        ADDR_ACK, PTR_ACK: begin
          if (sclFall) begin
            if (bitCnt_q == 4'd8) begin
              sdaOe_d  = 1'b1;
              bitCnt_d = 4'd9;
            end else if (state_q == ADDR_ACK && rw_q) begin
              state_d  = TX;
              sdaOe_d  = ~shift_q[7];
              bitCnt_d = 4'd1;
            end else begin
              state_d  = PTR;
              sdaOe_d  = 1'b0;
              bitCnt_d = '0;
            end
          end
        end

        PTR: begin
          if (sclRise) begin
            shift_d  = byteIn;
            bitCnt_d = bitCnt_q + 4'd1;
            if (bitCnt_q == 4'd7) begin
              if (!ptrSet_q) begin
                ptr_d    = byteIn[4:0];
                ptrSet_d = 1'b1;
                state_d  = PTR_ACK;
              end else begin
                state_d = IGNORE;
              end
            end
          end
        end

        TX: begin
          if (sclFall) begin
            if (bitCnt_q < 4'd8) begin
              shift_d  = {shift_q[6:0], 1'b0};
              sdaOe_d  = ~shift_q[6];
              bitCnt_d = bitCnt_q + 4'd1;
            end else begin
              sdaOe_d = 1'b0;
              state_d = TX_ACK;
            end
          end
        end

        // The byte is consumed either way, so the pointer advances on NACK as well.
        TX_ACK: begin
          if (sclRise && bitCnt_q == 4'd8) begin
            ptr_d   = ptr_q + 5'd1;
            radd_d  = ptr_q + 5'd1;
            pfCnt_d = PfStart;
            if (sdaSync_q) begin
              state_d = IGNORE;
            end else begin
              bitCnt_d = 4'd9;
            end
          end else if (sclFall && bitCnt_q == 4'd9) begin
            state_d  = TX;
            sdaOe_d  = ~shift_q[7];
            bitCnt_d = 4'd1;
          end
        end

        IGNORE: begin
          sdaOe_d = 1'b0;
        end

        default: ;
      endcase
    end
  end

  assign sda_oe        = sdaOe_q;
  assign slaveRAM_RADD = radd_q;
  assign busy          = busy_q;
  assign xfer_done     = xferDone_q;

endmodule

// File: tb/tb_i2c_slave_ram_port.sv
// Bench for i2c_slave_ram_port: a bit-banged I2C master plus a transaction-level
// model of the RAM pointer, ACK decisions and expected read data.
module tb_i2c_slave_ram_port;

  localparam logic [6:0] SlaveAddr = 7'h42;
  localparam int Q = 6;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclM = 1'b1;
  logic       sdaM = 1'b1;
  logic       sdaLine;
  logic       sda_oe;
  logic [4:0] radd;
  logic [7:0] dout = 8'h00;
  logic       busy;
  logic       xferDone;

  logic [7:0] mem [32];
  int total = 0;
  int bad = 0;

  logic expOe = 1'b0, oeValid = 1'b0;
  logic expBusy = 1'b0, busyValid = 1'b0;
  int   xferCnt = 0, xferBase = 0;

  logic [4:0] modelPtr = 5'd0;
  logic       modelMatched = 1'b0, modelAddrOk = 1'b0, modelRw = 1'b0;
  int         modelIdx = 0;
  logic [4:0] modelRaddLast = 5'd0;
  logic [4:0] expRadd[$];
  logic [4:0] obsRadd[$];
  logic [4:0] raddPrev = 5'd0;

  assign sdaLine = sdaM & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_ram_port #(.SLAVE_ADDR(SlaveAddr), .RAM_RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .scl_i(sclM), .sda_i(sdaLine), .sda_oe(sda_oe),
    .slaveRAM_RADD(radd), .slaveRAM_DOUT(dout), .busy(busy), .xfer_done(xferDone)
  );

  // Slave RAM controller read port with one clock of latency.
  always @(posedge clk) dout <= mem[radd];

  function automatic void check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
    end
  endfunction

  always @(negedge clk) begin
    if (xferDone) xferCnt++;
    if (radd !== raddPrev) begin
      obsRadd.push_back(radd);
      raddPrev = radd;
    end
  end

  // Cycle-by-cycle comparison of the bus-facing outputs against the model.
  always @(negedge clk) begin
    if (rst_n && oeValid) check("sda_oe", sda_oe, expOe);
    if (rst_n && busyValid) check("busy", busy, expBusy);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic modelRaddPush(input logic [4:0] v);
    if (v != modelRaddLast) expRadd.push_back(v);
    modelRaddLast = v;
  endtask

  task automatic masterBit(input logic drv, input logic oeExp, output logic seen);
    sdaM = drv;
    tick(Q);
    sclM = 1'b1;
    expOe = oeExp;
    oeValid = 1'b1;
    tick(Q);
    seen = sdaLine;
    tick(Q);
    oeValid = 1'b0;
    sclM = 1'b0;
    tick(Q);
  endtask

  task automatic startCond();
    busyValid = 1'b0;
    sdaM = 1'b1; tick(Q);
    sclM = 1'b1; tick(Q);
    sdaM = 1'b0; tick(Q);
    sclM = 1'b0; tick(Q);
    expBusy = 1'b1;
    busyValid = 1'b1;
    modelMatched = 1'b0;
  endtask

  task automatic stopCond(input string nm);
    busyValid = 1'b0;
    sdaM = 1'b0; tick(Q);
    sclM = 1'b1; tick(Q);
    sdaM = 1'b1; tick(2 * Q);
    expBusy = 1'b0;
    busyValid = 1'b1;
    check(nm, xferCnt - xferBase, modelMatched ? 1 : 0);
    xferBase = xferCnt;
    modelMatched = 1'b0;
  endtask

  task automatic writeByte(input logic [7:0] b, input logic ack);
    logic seen;
    for (int i = 7; i >= 0; i--) masterBit(b[i], 1'b0, seen);
    masterBit(1'b1, ack, seen);
    check("slave ack level", seen, ack ? 0 : 1);
  endtask

  task automatic sendAddr(input logic [6:0] a, input logic rw);
    modelAddrOk = (a == SlaveAddr);
    modelMatched = modelMatched | modelAddrOk;
    modelRw = rw;
    modelIdx = 0;
    if (modelAddrOk && rw) modelRaddPush(modelPtr);
    writeByte({a, rw}, modelAddrOk);
  endtask

  task automatic sendData(input logic [7:0] b);
    logic ack;
    ack = modelAddrOk && !modelRw && (modelIdx == 0);
    if (ack) modelPtr = b[4:0];
    modelIdx++;
    writeByte(b, ack);
  endtask

  task automatic readData(input logic mAck, output logic [7:0] got);
    logic [7:0] exp;
    logic seen;
    exp = mem[modelPtr];
    for (int i = 7; i >= 0; i--) begin
      masterBit(1'b1, ~exp[i], seen);
      got[i] = seen;
    end
    modelPtr = modelPtr + 5'd1;
    modelRaddPush(modelPtr);
    masterBit(mAck, 1'b0, seen);
    check("read byte", got, exp);
  endtask

  task automatic checkRadd(input string nm);
    check({nm, " count"}, obsRadd.size(), expRadd.size());
    for (int i = 0; i < expRadd.size() && i < obsRadd.size(); i++)
      check(nm, obsRadd[i], expRadd[i]);
    obsRadd.delete();
    expRadd.delete();
  endtask

  task automatic checkRaddLit(input string nm, input int k, input int v);
    if (k < obsRadd.size()) check(nm, obsRadd[k], v);
    else check({nm, " missing"}, obsRadd.size(), k + 1);
  endtask

  initial begin
    logic [7:0] got;
    logic seen;
    for (int a = 0; a < 32; a++) mem[a] = 8'(3 * a);

    tick(3);
    check("reset sda_oe", sda_oe, 0);
    check("reset radd", radd, 0);
    check("reset busy", busy, 0);
    check("reset xfer_done", xferDone, 0);
    rst_n = 1'b1;
    tick(Q);
    busyValid = 1'b1;

    // Test 1: set pointer 5, repeated START, read three bytes.
    startCond();
    sendAddr(SlaveAddr, 1'b0);
    sendData(8'h05);
    startCond();
    sendAddr(SlaveAddr, 1'b1);
    readData(1'b0, got); check("t1 byte0", got, 8'h0F);
    readData(1'b0, got); check("t1 byte1", got, 8'h12);
    readData(1'b1, got); check("t1 byte2", got, 8'h15);
    stopCond("t1 xfer_done");
    checkRaddLit("t1 radd0", 0, 5);
    checkRaddLit("t1 radd1", 1, 6);
    checkRaddLit("t1 radd2", 2, 7);
    checkRaddLit("t1 radd3", 3, 8);
    checkRadd("t1 radd");

    // Test 2: pointer wrap from 31 to 0.
    startCond();
    sendAddr(SlaveAddr, 1'b0);
    sendData(8'h1F);
    startCond();
    sendAddr(SlaveAddr, 1'b1);
    readData(1'b0, got); check("t2 byte0", got, 8'h5D);
    readData(1'b1, got); check("t2 byte1", got, 8'h00);
    stopCond("t2 xfer_done");
    checkRaddLit("t2 radd0", 0, 31);
    checkRaddLit("t2 radd1", 1, 0);
    checkRadd("t2 radd");

    // Test 3: foreign address is never acknowledged.
    startCond();
    sendAddr(7'h2A, 1'b0);
    sendData(8'h11);
    stopCond("t3 xfer_done");
    checkRadd("t3 radd");

    // Test 4: only the first write byte is accepted as the pointer.
    startCond();
    sendAddr(SlaveAddr, 1'b0);
    sendData(8'h03);
    sendData(8'hAA);
    stopCond("t4w xfer_done");
    startCond();
    sendAddr(SlaveAddr, 1'b1);
    readData(1'b1, got); check("t4 byte0", got, 8'h09);
    stopCond("t4r xfer_done");
    checkRadd("t4 radd");

    // Test 5: reset while the slave is driving the MSB of mem[4]=0x0C (a 0 bit).
    startCond();
    sendAddr(SlaveAddr, 1'b1);
    check("t5 slave drives 0", sda_oe, 1);
    rst_n = 1'b0;
    busyValid = 1'b0;
    #1;
    check("t5 sda_oe in reset", sda_oe, 0);
    check("t5 busy in reset", busy, 0);
    check("t5 radd in reset", radd, 0);
    modelPtr = 5'd0;
    modelMatched = 1'b0;
    modelRaddPush(5'd0);
    expBusy = 1'b0;
    sdaM = 1'b1;
    sclM = 1'b1;
    tick(Q);
    rst_n = 1'b1;
    tick(Q);
    busyValid = 1'b1;
    xferBase = xferCnt;
    startCond();
    sendAddr(SlaveAddr, 1'b1);
    readData(1'b1, got); check("t5 byte0", got, 8'h00);
    stopCond("t5 xfer_done");
    checkRadd("t5 radd");

    // Test 6: STOP after four address bits, then a full transaction.
    startCond();
    masterBit(1'b1, 1'b0, seen);
    masterBit(1'b0, 1'b0, seen);
    masterBit(1'b0, 1'b0, seen);
    masterBit(1'b0, 1'b0, seen);
    stopCond("t6a xfer_done");
    check("t6 sda_oe after stop", sda_oe, 0);
    check("t6 busy after stop", busy, 0);
    startCond();
    sendAddr(SlaveAddr, 1'b0);
    sendData(8'h0A);
    startCond();
    sendAddr(SlaveAddr, 1'b1);
    readData(1'b0, got); check("t6 byte0", got, 8'h1E);
    readData(1'b1, got); check("t6 byte1", got, 8'h21);
    stopCond("t6b xfer_done");
    checkRadd("t6 radd");

    tick(Q);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
